// File: rtl/stage_pkg.sv
// Shared definitions for the multicycle stage sequencer.
//   stage_t     : 3-bit state encoding, also exported on the stage port.
//   WAIT_MAX_D  : default limit of consecutive MA wait cycles before fault.
//   CNT_W_D     : default width of the retired-instruction counter.
//   WAIT_CNT_W  : width of the MA wait counter.
package stage_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FT    = 3'd1,
        S_DC    = 3'd2,
        S_EX    = 3'd3,
        S_MA    = 3'd4,
        S_WB    = 3'd5,
        S_HALT  = 3'd6,
        S_FAULT = 3'd7
    } stage_t;

    localparam int unsigned WAIT_MAX_D = 255;
    localparam int unsigned CNT_W_D    = 32;
    localparam int unsigned WAIT_CNT_W = 16;

endpackage

// File: rtl/seq_wait_cnt.sv
// MA wait counter.
// Counts consecutive memory-access cycles spent waiting on the MMU and
// flags when the count has reached the last permitted wait cycle.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   clr_i      : force the count to zero
//   inc_i      : increment the count (ignored while clr_i is high)
//   expired_o  : count equals LIMIT-1, i.e. the next wait would exceed LIMIT
module seq_wait_cnt
    import stage_pkg::*;
#(
    parameter int unsigned LIMIT = WAIT_MAX_D
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam logic [WAIT_CNT_W-1:0] LAST = WAIT_CNT_W'(LIMIT - 1);

    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + WAIT_CNT_W'(1);
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/stage_seq.sv
// Multicycle stage sequencer for the RV32 core.
// Walks FT -> DC -> EX -> [MA] -> WB on a single clock, raising one stage
// enable per cycle so all datapath registers share CLK and are gated by the
// enables. MA is skipped for non-memory instructions; FT and MA stretch on
// memory wait. Supports halt at instruction boundaries, single step, and a
// sticky fault when MA waits too long.
//   CLK, RST                      : clock, synchronous active-high reset
//   halt_req                      : level, stop at the next instruction boundary
//   step_req                      : pulse, run one instruction while halted
//   imem_wait / rwmem / mem_wait  : fetch stall / memory instr / MMU stall
//   en_ft..en_wb                  : one-hot stage enables
//   stage                         : current state encoding
//   retire, instret               : WB pulse, retired-instruction count
//   halted, fault                 : in S_HALT, in S_FAULT
module stage_seq
    import stage_pkg::*;
#(
    parameter int unsigned WAIT_MAX = WAIT_MAX_D,
    parameter int unsigned CNT_W    = CNT_W_D
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             imem_wait,
    input  logic             rwmem,
    input  logic             mem_wait,
    output logic             en_ft,
    output logic             en_dc,
    output logic             en_ex,
    output logic             en_ma,
    output logic             en_wb,
    output stage_t           stage,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic             fault
);

    stage_t           state_q, state_d;
    logic             step_pend_q, step_pend_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             wait_expired;

    // Held at zero whenever outside MA, so every MA entry starts from zero.
    seq_wait_cnt #(
        .LIMIT (WAIT_MAX)
    ) u_wait_cnt (
        .clk_i     (CLK),
        .rst_i     (RST),
        .clr_i     (state_q != S_MA),
        .inc_i     ((state_q == S_MA) && mem_wait),
        .expired_o (wait_expired)
    );

    // NOTE: every variable driven here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        step_pend_d = step_pend_q;
        instret_d   = instret_q;
        unique case (state_q)
            S_IDLE:  state_d = halt_req ? S_HALT : S_FT;
            S_FT:    if (!imem_wait) state_d = S_DC;
            S_DC:    state_d = S_EX;
            S_EX:    state_d = rwmem ? S_MA : S_WB;
            S_MA: begin
                if (!mem_wait) begin
                    state_d = S_WB;
                end else if (wait_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_WB: begin
                instret_d   = instret_q + CNT_W'(1);
                state_d     = (halt_req || step_pend_q) ? S_HALT : S_FT;
                step_pend_d = 1'b0;
            end
            S_HALT: begin
                // A step request returns to HALT after one instruction even if
                // halt_req drops in the same cycle.
                if (step_req) begin
                    state_d     = S_FT;
                    step_pend_d = 1'b1;
                end else if (!halt_req) begin
                    state_d = S_FT;
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            step_pend_q <= 1'b0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            step_pend_q <= step_pend_d;
            instret_q   <= instret_d;
        end
    end

    // Moore decodes of the registered state.
    always_comb begin
        en_ft  = 1'b0;
        en_dc  = 1'b0;
        en_ex  = 1'b0;
        en_ma  = 1'b0;
        en_wb  = 1'b0;
        retire = 1'b0;
        halted = 1'b0;
        fault  = 1'b0;
        unique case (state_q)
            S_FT:    en_ft = 1'b1;
            S_DC:    en_dc = 1'b1;
            S_EX:    en_ex = 1'b1;
            S_MA:    en_ma = 1'b1;
            S_WB: begin
                en_wb  = 1'b1;
                retire = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: ;
        endcase
    end

    assign stage   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_stage_seq.sv
// Scoreboard bench for stage_seq (WAIT_MAX=4, CNT_W=4).
// The stimulus process pushes the hand-expected per-cycle response; the
// monitor pops and compares on each falling edge.
module tb_stage_seq;
    import stage_pkg::*;

    typedef struct packed {
        logic [2:0] stage;
        logic [4:0] en;      // {ft, dc, ex, ma, wb}
        logic       retire;
        logic       halted;
        logic       fault;
        logic [3:0] instret;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       halt_req, step_req, imem_wait, rwmem, mem_wait;
    logic       en_ft, en_dc, en_ex, en_ma, en_wb;
    logic [2:0] stage;
    logic       retire, halted, fault;
    logic [3:0] instret;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];
    logic [3:0] exp_instret = 4'd0;

    always #5 clk = ~clk;

    stage_seq #(
        .WAIT_MAX (4),
        .CNT_W    (4)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .halt_req  (halt_req),
        .step_req  (step_req),
        .imem_wait (imem_wait),
        .rwmem     (rwmem),
        .mem_wait  (mem_wait),
        .en_ft     (en_ft),
        .en_dc     (en_dc),
        .en_ex     (en_ex),
        .en_ma     (en_ma),
        .en_wb     (en_wb),
        .stage     (stage),
        .retire    (retire),
        .instret   (instret),
        .halted    (halted),
        .fault     (fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [4:0] en_of(input logic [2:0] s);
        case (s)
            S_FT:    return 5'b10000;
            S_DC:    return 5'b01000;
            S_EX:    return 5'b00100;
            S_MA:    return 5'b00010;
            S_WB:    return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    // Push the expected response for the current cycle, then advance one clock.
    task automatic tick(input logic [2:0] s);
        exp_t e;
        e.stage   = s;
        e.en      = en_of(s);
        e.retire  = (s == S_WB);
        e.halted  = (s == S_HALT);
        e.fault   = (s == S_FAULT);
        e.instret = exp_instret;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (rst) exp_instret = 4'd0;
        else if (s == S_WB) exp_instret = exp_instret + 4'd1;
    endtask

    task automatic plain_instr();
        tick(S_FT); tick(S_DC); tick(S_EX); tick(S_WB);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("stage",   32'(stage), 32'(e.stage));
            check("enables", 32'({en_ft, en_dc, en_ex, en_ma, en_wb}), 32'(e.en));
            check("retire",  32'(retire), 32'(e.retire));
            check("halted",  32'(halted), 32'(e.halted));
            check("fault",   32'(fault), 32'(e.fault));
            check("instret", 32'(instret), 32'(e.instret));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; halt_req = 1'b0; step_req = 1'b0;
        imem_wait = 1'b0; rwmem = 1'b0; mem_wait = 1'b0;
        @(posedge clk);
        #1;
        // Reset held over three edges.
        tick(S_IDLE); tick(S_IDLE);
        rst = 1'b0;

        // First instruction after release: retire on cycle 5, instret -> 1.
        tick(S_IDLE);
        plain_instr();

        // Memory instruction, three MA wait cycles (one short of the limit).
        tick(S_FT); tick(S_DC);
        rwmem = 1'b1; tick(S_EX); rwmem = 1'b0;
        mem_wait = 1'b1; tick(S_MA); tick(S_MA); tick(S_MA);
        mem_wait = 1'b0; tick(S_MA);
        tick(S_WB);

        // Fetch wait: FT lasts three cycles.
        imem_wait = 1'b1; tick(S_FT); tick(S_FT);
        imem_wait = 1'b0; tick(S_FT);
        tick(S_DC); tick(S_EX); tick(S_WB);

        // Halt requested during DC: instruction completes, then HALT.
        tick(S_FT);
        halt_req = 1'b1;
        tick(S_DC); tick(S_EX); tick(S_WB);
        repeat (10) tick(S_HALT);

        // Single step with halt_req held.
        step_req = 1'b1; tick(S_HALT); step_req = 1'b0;
        plain_instr();
        tick(S_HALT); tick(S_HALT);

        // Step with halt_req dropping in the same cycle: still returns to HALT.
        step_req = 1'b1; halt_req = 1'b0; tick(S_HALT); step_req = 1'b0;
        plain_instr();
        tick(S_HALT);  // halt_req low here, so free-running resumes

        // step_req outside HALT is ignored.
        tick(S_FT); tick(S_DC);
        step_req = 1'b1; tick(S_EX); step_req = 1'b0;
        tick(S_WB);

        // Timeout: MMU stuck busy, fault after four MA cycles.
        tick(S_FT); tick(S_DC);
        rwmem = 1'b1; tick(S_EX); rwmem = 1'b0;
        mem_wait = 1'b1;
        repeat (4) tick(S_MA);
        tick(S_FAULT); tick(S_FAULT);
        step_req = 1'b1; halt_req = 1'b1; tick(S_FAULT);
        step_req = 1'b0; halt_req = 1'b0; tick(S_FAULT); tick(S_FAULT);
        check("instret_before_fault_clear", 32'(instret), 32'd7);

        // Reset out of fault clears fault and instret.
        rst = 1'b1; tick(S_FAULT);
        rst = 1'b0; mem_wait = 1'b0;
        tick(S_IDLE);

        // Sixteen retirements wrap the 4-bit counter back to zero.
        repeat (16) plain_instr();
        check("instret_wrap", 32'(instret), 32'd0);

        // One more, then reset in EX: no WB, instret cleared.
        plain_instr();
        tick(S_FT); tick(S_DC);
        rst = 1'b1; tick(S_EX);
        rst = 1'b0; tick(S_IDLE);
        tick(S_FT);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
